// File: rtl/i2c_pkg.sv
// Shared types and field offsets for the single-byte I2C master core.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_DATA,
    ST_ACK2,
    ST_STOP
  } state_t;

  // data0 command word fields
  localparam int D0_ADDR_LSB  = 0;
  localparam int D0_ADDR_W    = 7;
  localparam int D0_RW_BIT    = 7;
  localparam int D0_WBYTE_LSB = 8;
  localparam int D0_GO_BIT    = 31;

  // data1 timing word fields
  localparam int D1_DIV_LSB = 0;
  localparam int D1_DIV_W   = 16;

  // status bit positions as seen by the CSR block
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_ACK_ERR_BIT = 1;
  localparam int STAT_DONE_BIT    = 2;
  localparam int STAT_DREADY_BIT  = 3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: divider counter plus 0..3 quarter counter.
// With I2C_CLK_STRETCH_EN defined, q1 is held until the synchronised SCL reads high.
module i2c_tick_gen
  import i2c_pkg::*;
(
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [D1_DIV_W-1:0] i_div,
  input  logic                i_scl,
  output logic                o_tick,
  output logic [1:0]          o_q
);

  logic [D1_DIV_W-1:0] r_cnt;
  logic [1:0]          r_q;
  logic                w_hold;
  logic [D1_DIV_W-1:0] w_div_m1;

`ifdef I2C_CLK_STRETCH_EN
  // keep the counter parked at 0 so the high time is a full D once SCL is seen high
  assign w_hold = (r_q == 2'd1) && !i_scl;
`else
  logic w_unused_scl;
  assign w_unused_scl = i_scl;
  assign w_hold       = 1'b0;
`endif

  assign w_div_m1 = i_div - D1_DIV_W'(1);
  assign o_tick   = i_en && !w_hold && (r_cnt == w_div_m1);
  assign o_q      = r_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (w_hold) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_cnt <= r_cnt + D1_DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_core.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP per GO edge.
// Optional clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter logic [15:0] DEF_DIV = 16'd250
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [31:0] data2,
  output logic        status_busy,
  output logic        status_ack_err,
  output logic        status_done,
  output logic        status_data_ready,
  input  logic        scl_i,
  output logic        scl_oe,
  input  logic        sda_i,
  output logic        sda_oe
);

  state_t      r_state;
  logic [15:0] r_cmd;
  logic [15:0] r_div;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx;
  logic [2:0]  r_bit;
  logic        r_sample;
  logic        r_go_q, r_go_edge;
  logic        r_busy, r_ack_err, r_done, r_dready;
  logic        r_scl_oe, r_sda_oe;
  logic        r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
  logic        w_tick;
  logic [1:0]  w_q;
  logic        w_tx_bit;
  logic        w_unused_bits;

  assign w_unused_bits = ^{data0[30:16], data1[31:16]};

  i2c_tick_gen u_tick (
    .clk    (clk),
    .i_rst  (reset),
    .i_en   (r_busy),
    .i_div  (r_div),
    .i_scl  (r_scl_sync),
    .o_tick (w_tick),
    .o_q    (w_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_meta <= 1'b0;
      r_scl_sync <= 1'b0;
      r_sda_meta <= 1'b0;
      r_sda_sync <= 1'b0;
    end else begin
      r_scl_meta <= scl_i;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= sda_i;
      r_sda_sync <= r_sda_meta;
    end
  end

  // SDA is released (1) for ACK slots, read data and the master's NACK
  always_comb begin
    w_tx_bit = 1'b1;
    if (r_state == ST_ADDR || (r_state == ST_DATA && !r_cmd[D0_RW_BIT]))
      w_tx_bit = r_shift[7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_div     <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_bit     <= '0;
      r_sample  <= 1'b0;
      r_go_q    <= 1'b0;
      r_go_edge <= 1'b0;
      r_busy    <= 1'b0;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
      r_dready  <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_go_q    <= data0[D0_GO_BIT];
      r_go_edge <= data0[D0_GO_BIT] && !r_go_q;

      case (r_state)
        ST_IDLE: begin
          r_scl_oe <= 1'b0;
          r_sda_oe <= 1'b0;
        end
        ST_START: begin
          r_scl_oe <= (w_q >= 2'd2);
          r_sda_oe <= (w_q != 2'd0);
        end
        ST_STOP: begin
          r_scl_oe <= (w_q == 2'd0);
          r_sda_oe <= (w_q <= 2'd1);
        end
        default: begin
          r_scl_oe <= (w_q == 2'd0) || (w_q == 2'd3);
          r_sda_oe <= !w_tx_bit;
        end
      endcase

      if (r_state == ST_IDLE) begin
        if (r_go_edge) begin
          r_cmd     <= data0[15:0];
          r_div     <= (data1[D1_DIV_LSB +: D1_DIV_W] == '0) ? DEF_DIV : data1[D1_DIV_LSB +: D1_DIV_W];
          r_shift   <= {data0[D0_ADDR_LSB +: D0_ADDR_W], data0[D0_RW_BIT]};
          r_ack_err <= 1'b0;
          r_done    <= 1'b0;
          r_dready  <= 1'b0;
          r_busy    <= 1'b1;
          r_state   <= ST_START;
        end
      end else if (w_tick) begin
        if (w_q == 2'd2)
          r_sample <= r_sda_sync;
        if (w_q == 2'd3) begin
          case (r_state)
            ST_START: begin
              r_state <= ST_ADDR;
              r_bit   <= '0;
            end
            ST_ADDR: begin
              r_shift <= {r_shift[6:0], 1'b0};
              if (r_bit == 3'd7) r_state <= ST_ACK1;
              else               r_bit   <= r_bit + 3'd1;
            end
            ST_ACK1: begin
              if (r_sample) begin
                r_ack_err <= 1'b1;
                r_state   <= ST_STOP;
              end else begin
                r_shift <= r_cmd[D0_WBYTE_LSB +: 8];
                r_bit   <= '0;
                r_state <= ST_DATA;
              end
            end
            ST_DATA: begin
              // on writes the shifted-in sample is discarded with the byte
              r_shift <= {r_shift[6:0], r_sample};
              if (r_bit == 3'd7) r_state <= ST_ACK2;
              else               r_bit   <= r_bit + 3'd1;
            end
            ST_ACK2: begin
              if (r_cmd[D0_RW_BIT]) begin
                r_rx     <= r_shift;
                r_dready <= 1'b1;
              end else if (r_sample) begin
                r_ack_err <= 1'b1;
              end
              r_state <= ST_STOP;
            end
            ST_STOP: begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign data2             = {24'h0, r_rx};
  assign status_busy       = r_busy;
  assign status_ack_err    = r_ack_err;
  assign status_done       = r_done;
  assign status_data_ready = r_dready;
  assign scl_oe            = r_scl_oe;
  assign sda_oe            = r_sda_oe;

endmodule

// File: tb/tb_i2c_master_core.sv
// Self-checking bench: open-drain bus, behavioural slave, transaction-level reference model.
module tb_i2c_master_core;

  localparam logic [15:0] TB_DEF_DIV = 16'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2;
  logic        status_busy, status_ack_err, status_done, status_data_ready;
  logic        scl_i, scl_oe, sda_i, sda_oe;

  bit   slv_sda_low = 0, slv_scl_low = 0;
  bit   slv_rw, slv_nack_addr, slv_nack_data;
  logic [7:0] slv_rd;
  int   bit_cnt = 0, start_cnt = 0, stop_cnt = 0, done_rises = 0, stretch_left = 0;
  bit   stretch_en = 0, prev_done = 0, p_scl = 1, p_sda = 1;
  bit   bits[$];

  int   n_checks = 0, n_errors = 0, n_txn = 0;
  logic [7:0] exp_rx = 8'h00;

  assign scl_i = !scl_oe && !slv_scl_low;
  assign sda_i = !sda_oe && !slv_sda_low;

  always #5 clk = ~clk;

  i2c_master_core #(.DEF_DIV(TB_DEF_DIV)) dut (
    .clk               (clk),
    .reset             (reset),
    .data0             (data0),
    .data1             (data1),
    .data2             (data2),
    .status_busy       (status_busy),
    .status_ack_err    (status_ack_err),
    .status_done       (status_done),
    .status_data_ready (status_data_ready),
    .scl_i             (scl_i),
    .scl_oe            (scl_oe),
    .sda_i             (sda_i),
    .sda_oe            (sda_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural slave and bus monitor, evaluated on the falling clock edge
  initial begin
    bit s, a, drv;
    forever begin
      @(negedge clk);
      s = scl_i;
      a = sda_i;
      if (status_done && !prev_done) done_rises++;
      prev_done = status_done;
      if (p_scl && s && p_sda && !a) begin
        start_cnt++;
        bit_cnt = 0;
      end else if (p_scl && s && !p_sda && a) begin
        stop_cnt++;
        if (bits.size() > 0) void'(bits.pop_back());
      end
      if (!p_scl && s) begin
        bits.push_back(a);
        if (bit_cnt == 7) slv_rw = a;
        bit_cnt++;
      end
      if (p_scl && !s) begin
        drv = 0;
        if (bit_cnt == 8) drv = !slv_nack_addr;
        else if (bit_cnt >= 9 && bit_cnt <= 16 && slv_rw && !slv_nack_addr) drv = !slv_rd[16-bit_cnt];
        else if (bit_cnt == 17 && !slv_rw) drv = !slv_nack_data;
        slv_sda_low = drv;
        if (stretch_en && bit_cnt == 8) stretch_left = 50;
      end
      if (stretch_left > 0) begin
        slv_scl_low = 1;
        stretch_left--;
      end else begin
        slv_scl_low = 0;
      end
      p_scl = scl_i;
      p_sda = sda_i;
    end
  end

  task automatic run_txn(input logic [6:0] addr, input bit rw, input logic [7:0] wb,
                         input logic [15:0] d, input bit nack_a, input bit nack_d,
                         input logic [7:0] rdb, input bit toggle_go);
    int lat, busy_cyc, eff_d, exp_busy;
    bit exp_bits[$];
    logic [7:0] byte_v;
    logic [31:0] gv, ev;
    slv_nack_addr = nack_a;
    slv_nack_data = nack_d;
    slv_rd = rdb;
    @(negedge clk);
    bits.delete();
    start_cnt = 0; stop_cnt = 0; done_rises = 0;
    data1 = {16'($urandom), d};
    data0 = {1'b0, 15'($urandom), wb, rw, addr};
    @(negedge clk);
    data0[31] = 1'b1;
    lat = 0;
    while (!status_busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("go_latency", lat, 2);
    busy_cyc = 0;
    while (status_busy && busy_cyc < 20000) begin
      busy_cyc++;
      if (toggle_go && busy_cyc == 40) data0[31] = 1'b0;
      if (toggle_go && busy_cyc == 41) data0[31] = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("idle_after", status_busy, 0);
    check("done_once", done_rises, 1);
    data0[31] = 1'b0;

    // reference model of the transaction
    eff_d    = (d == 0) ? int'(TB_DEF_DIV) : int'(d);
    exp_busy = (nack_a ? 44 : 80) * eff_d;
    byte_v = {addr, rw};
    for (int i = 7; i >= 0; i--) exp_bits.push_back(byte_v[i]);
    exp_bits.push_back(nack_a);
    if (!nack_a) begin
      byte_v = rw ? rdb : wb;
      for (int i = 7; i >= 0; i--) exp_bits.push_back(byte_v[i]);
      exp_bits.push_back(rw ? 1'b1 : nack_d);
      if (rw) exp_rx = rdb;
    end
`ifdef I2C_CLK_STRETCH_EN
    check("busy_min", busy_cyc >= exp_busy + (stretch_en ? 50 : 0), 1);
`else
    check("busy_cycles", busy_cyc, exp_busy);
`endif
    check("done", status_done, 1);
    check("ack_err", status_ack_err, nack_a || (!rw && nack_d));
    check("data_ready", status_data_ready, rw && !nack_a);
    check("data2", data2, {24'h0, exp_rx});
    check("starts", start_cnt, 1);
    check("stops", stop_cnt, 1);
    check("nbits", bits.size(), exp_bits.size());
    gv = '0;
    ev = '0;
    for (int i = 0; i < bits.size() && i < 32; i++) gv = {gv[30:0], bits[i]};
    for (int i = 0; i < exp_bits.size(); i++) ev = {ev[30:0], exp_bits[i]};
    check("sda_bits", gv, ev);
    n_txn++;
    $display("txn %0d addr=%02h rw=%0b wb=%02h d=%0d nack_a=%0b nack_d=%0b busy=%0d data2=%08h",
             n_txn, addr, rw, wb, eff_d, nack_a, nack_d, busy_cyc, data2);
  endtask

  initial begin
    int guard;
    logic [15:0] d_tab [6];
    d_tab = '{16'd0, 16'd3, 16'd4, 16'd5, 16'd7, 16'd9};

    repeat (3) @(negedge clk);
    check("rst_busy", status_busy, 0);
    check("rst_status", {status_ack_err, status_done, status_data_ready}, 0);
    check("rst_lines", {scl_oe, sda_oe}, 0);
    check("rst_data2", data2, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(7'h50, 1'b0, 8'hA5, 16'd4, 0, 0, 8'h00, 0);
    run_txn(7'h50, 1'b1, 8'h00, 16'd4, 0, 0, 8'h3C, 0);
    run_txn(7'h50, 1'b0, 8'h12, 16'd4, 1, 0, 8'h00, 0);
    run_txn(7'h21, 1'b0, 8'h5A, 16'd4, 0, 1, 8'h00, 1);

    // reset during the address byte
    @(negedge clk);
    data1 = 32'd4;
    data0 = {1'b0, 15'd0, 8'h11, 1'b0, 7'h2A};
    slv_nack_addr = 0;
    bit_cnt = 0;
    @(negedge clk);
    data0[31] = 1'b1;
    guard = 0;
    while (bit_cnt < 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reach", guard < 2000, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_lines", {scl_oe, sda_oe}, 0);
    check("rst_mid_status", {status_busy, status_ack_err, status_done, status_data_ready}, 0);
    check("rst_mid_data2", data2, 0);
    exp_rx = 8'h00;
    repeat (2) @(negedge clk);
    data0[31] = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_txn(7'h2A, 1'b0, 8'h11, 16'd4, 0, 0, 8'h00, 0);

    run_txn(7'h33, 1'b1, 8'h00, 16'd0, 0, 0, 8'hC3, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(7'($urandom), 1'($urandom), 8'($urandom), d_tab[$urandom_range(0, 5)],
              ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom), 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    stretch_en = 1;
    run_txn(7'h50, 1'b0, 8'hA5, 16'd4, 0, 0, 8'h00, 0);
    stretch_en = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
